// File: rtl/tpu_ctrl_pkg.sv
// Shared definitions for the TPU tile-sequencing control path.
package tpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_W_MEM_FIFO = 3'd1,
    ST_W_FIFO_ARR = 3'd2,
    ST_D_MEM_CALC = 3'd3,
    ST_FINISH     = 3'd4
  } tile_state_e;

  // Width of a tile index for an output dimension of max_dim split into edge_sz tiles.
  // Clamped to 1 bit so a single-tile dimension still gets a legal port.
  function automatic int tile_idx_w(input int max_dim, input int edge_sz);
    int n;
    n = max_dim / edge_sz;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/master_tile_seq_tile_counter.sv
// Row/column tile index pair; row is the inner index, column advances on row wrap.
module tile_counter #(
  parameter int ROW_W = 3,
  parameter int COL_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             advance,
  input  logic [ROW_W-1:0] max_row,
  input  logic [COL_W-1:0] max_col,
  output logic [ROW_W-1:0] row_q,
  output logic [COL_W-1:0] col_q,
  output logic [ROW_W-1:0] row_d,
  output logic [COL_W-1:0] col_d,
  output logic             last_row,
  output logic             last_col
);

  assign last_row = (row_q == max_row);
  assign last_col = (col_q == max_col);

  // Next index pair; exposed so the parent can register addresses in step with the indices
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear) begin
      row_d = '0;
      col_d = '0;
    end else if (advance) begin
      if (last_row) begin
        row_d = '0;
        col_d = col_q + COL_W'(1);
      end else begin
        row_d = row_q + ROW_W'(1);
      end
    end
  end

  // Index registers
  always_ff @(posedge clk) begin
    if (reset) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/master_tile_seq.sv
// Tile sequencer: walks column-outer/row-inner over output tiles, loading weights
// once per column and optionally prefetching the next column's weights during the
// last row tile of the current column.
module master_tile_seq
  import tpu_ctrl_pkg::*;
#(
  parameter  int WIDTH_HEIGHT = 16,
  parameter  int MAX_OUT_ROWS = 128,
  parameter  int MAX_OUT_COLS = 128,
  parameter  int ADDR_W       = 16,
  localparam int ROW_W        = tile_idx_w(MAX_OUT_ROWS, WIDTH_HEIGHT),
  localparam int COL_W        = tile_idx_w(MAX_OUT_COLS, WIDTH_HEIGHT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              overlap_en,
  input  logic [ROW_W-1:0]  num_tile_rows,
  input  logic [COL_W-1:0]  num_tile_cols,
  input  logic [ADDR_W-1:0] base_weight,
  input  logic [ADDR_W-1:0] base_data,
  input  logic              weight_mem_fifo_done,
  input  logic              weight_fifo_arr_done,
  input  logic              data_mem_calc_done,
  output logic              weight_mem_fifo_en,
  output logic              weight_fifo_arr_en,
  output logic              data_mem_calc_en,
  output logic [ADDR_W-1:0] weight_addr,
  output logic [ADDR_W-1:0] data_addr,
  output logic [ROW_W-1:0]  accum_table_submat_row,
  output logic [COL_W-1:0]  accum_table_submat_col,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] TILE_WORDS = ADDR_W'(WIDTH_HEIGHT * WIDTH_HEIGHT);

  tile_state_e       state_q, state_d;
  logic              busy_q, busy_d, done_q, done_d, pf_ok_q, pf_ok_d;
  logic              wm_en_q, wm_en_d, wa_en_q, wa_en_d, dc_en_q, dc_en_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d, daddr_q, daddr_d;
  logic              ovl_q, ovl_d;
  logic [ROW_W-1:0]  rows_q, rows_d;
  logic [COL_W-1:0]  cols_q, cols_d;
  logic [ADDR_W-1:0] bw_q, bw_d, bd_q, bd_d;
  logic              cfg_ld, cnt_clear, cnt_adv, gap, pf_tgt;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              last_row, last_col;
  logic              wm_hit, wa_hit, dc_hit;

  // A done strobe only counts while its phase enable is up
  assign wm_hit = weight_mem_fifo_done & wm_en_q;
  assign wa_hit = weight_fifo_arr_done & wa_en_q;
  assign dc_hit = data_mem_calc_done   & dc_en_q;

  tile_counter #(.ROW_W(ROW_W), .COL_W(COL_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (cnt_clear),
    .advance  (cnt_adv),
    .max_row  (rows_q),
    .max_col  (cols_q),
    .row_q    (row_q),
    .col_q    (col_q),
    .row_d    (row_d),
    .col_d    (col_d),
    .last_row (last_row),
    .last_col (last_col)
  );

  // Configuration is captured only when a start is accepted
  always_comb begin
    ovl_d  = ovl_q;
    rows_d = rows_q;
    cols_d = cols_q;
    bw_d   = bw_q;
    bd_d   = bd_q;
    if (cfg_ld) begin
      ovl_d  = overlap_en;
      rows_d = num_tile_rows;
      cols_d = num_tile_cols;
      bw_d   = base_weight;
      bd_d   = base_data;
    end
  end

  // Next-state logic; prefetch completion is tracked in pf_ok while calc runs
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    pf_ok_d   = pf_ok_q;
    cfg_ld    = 1'b0;
    cnt_clear = 1'b0;
    cnt_adv   = 1'b0;
    gap       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cfg_ld    = 1'b1;
          cnt_clear = 1'b1;
          busy_d    = 1'b1;
          pf_ok_d   = 1'b0;
          state_d   = ST_W_MEM_FIFO;
        end
      end
      ST_W_MEM_FIFO: begin
        if (wm_hit) begin
          state_d = ST_W_FIFO_ARR;
          pf_ok_d = 1'b0;
        end
      end
      ST_W_FIFO_ARR: begin
        if (wa_hit) state_d = ST_D_MEM_CALC;
      end
      ST_D_MEM_CALC: begin
        if (wm_hit) pf_ok_d = 1'b1;
        if (dc_hit) begin
          if (last_row && last_col) begin
            state_d = ST_FINISH;
          end else begin
            cnt_adv = 1'b1;
            if (!last_row) begin
              gap = 1'b1;
            end else if (pf_ok_q || wm_hit) begin
              state_d = ST_W_FIFO_ARR;
              pf_ok_d = 1'b0;
            end else begin
              // prefetch still running: its enable carries straight over
              state_d = ST_W_MEM_FIFO;
            end
          end
        end
      end
      ST_FINISH: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs decoded from the next state and next indices
  always_comb begin
    pf_tgt  = (state_d == ST_D_MEM_CALC) && ovl_q &&
              (row_d == rows_q) && (col_d != cols_q);
    dc_en_d = (state_d == ST_D_MEM_CALC) && !gap;
    wm_en_d = (state_d == ST_W_MEM_FIFO) || (pf_tgt && dc_en_d && !pf_ok_d);
    wa_en_d = (state_d == ST_W_FIFO_ARR);
    done_d  = (state_d == ST_FINISH);
    waddr_d = bw_d + (ADDR_W'(col_d) + ADDR_W'(pf_tgt)) * TILE_WORDS;
    daddr_d = bd_d + ADDR_W'(row_d) * TILE_WORDS;
  end

  // State, flags, outputs and configuration registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pf_ok_q <= 1'b0;
      wm_en_q <= 1'b0;
      wa_en_q <= 1'b0;
      dc_en_q <= 1'b0;
      waddr_q <= '0;
      daddr_q <= '0;
      ovl_q   <= 1'b0;
      rows_q  <= '0;
      cols_q  <= '0;
      bw_q    <= '0;
      bd_q    <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pf_ok_q <= pf_ok_d;
      wm_en_q <= wm_en_d;
      wa_en_q <= wa_en_d;
      dc_en_q <= dc_en_d;
      waddr_q <= waddr_d;
      daddr_q <= daddr_d;
      ovl_q   <= ovl_d;
      rows_q  <= rows_d;
      cols_q  <= cols_d;
      bw_q    <= bw_d;
      bd_q    <= bd_d;
    end
  end

  assign weight_mem_fifo_en     = wm_en_q;
  assign weight_fifo_arr_en     = wa_en_q;
  assign data_mem_calc_en       = dc_en_q;
  assign weight_addr            = waddr_q;
  assign data_addr              = daddr_q;
  assign accum_table_submat_row = row_q;
  assign accum_table_submat_col = col_q;
  assign busy                   = busy_q;
  assign done                   = done_q;

endmodule

// File: tb/tb_master_tile_seq.sv
// Scoreboard bench for master_tile_seq: tests queue expected phase events,
// a monitor pops and compares on every rising enable / done pulse.
module tb_master_tile_seq;

  localparam int K_TILE = 0, K_WLOAD = 1, K_WARR = 2, K_DONE = 3;
  localparam int BW = 16'h1000, BD = 16'h4000;

  logic        clk = 0, reset = 1, start = 0, overlap_en = 0;
  logic [2:0]  num_tile_rows = 0, num_tile_cols = 0;
  logic [15:0] base_weight = 0, base_data = 0;
  logic        wmd = 0, wad = 0, dcd = 0;
  logic        wm_en, wa_en, dc_en, busy, done;
  logic [15:0] waddr, daddr;
  logic [2:0]  row, col;

  master_tile_seq dut (
    .clk(clk), .reset(reset), .start(start), .overlap_en(overlap_en),
    .num_tile_rows(num_tile_rows), .num_tile_cols(num_tile_cols),
    .base_weight(base_weight), .base_data(base_data),
    .weight_mem_fifo_done(wmd), .weight_fifo_arr_done(wad), .data_mem_calc_done(dcd),
    .weight_mem_fifo_en(wm_en), .weight_fifo_arr_en(wa_en), .data_mem_calc_en(dc_en),
    .weight_addr(waddr), .data_addr(daddr),
    .accum_table_submat_row(row), .accum_table_submat_col(col),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { int kind; int r; int c; int a; int ovl; } evt_t;
  evt_t exp_q[$];
  int n_checks = 0, n_pass = 0;

  // ---------------- scoreboard ----------------
  task automatic ex(input int k, input int r, input int c, input int a, input int o);
    evt_t e;
    e.kind = k; e.r = r; e.c = c; e.a = a; e.ovl = o;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int k, input int r, input int c, input int a, input int o);
    evt_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL evt unexpected: got kind=%0d r=%0d c=%0d a=%h ovl=%0d, queue empty",
               k, r, c, a, o);
    end else begin
      e = exp_q.pop_front();
      if (e.kind == k && e.r == r && e.c == c && e.a == a && e.ovl == o) n_pass++;
      else $display("FAIL evt: got kind=%0d r=%0d c=%0d a=%h ovl=%0d, want kind=%0d r=%0d c=%0d a=%h ovl=%0d",
                    k, r, c, a, o, e.kind, e.r, e.c, e.a, e.ovl);
    end
  endtask

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d (0x%h), want %0d (0x%h)", name, got, got, want, want);
  endtask

  // monitor: one event per rising enable / done
  logic dc_p = 0, wm_p = 0, wa_p = 0, dn_p = 0;
  always @(negedge clk) begin
    if (dc_en && !dc_p) observe(K_TILE, int'(row), int'(col), int'(daddr), int'(dc_en & wm_en));
    if (wm_en && !wm_p) observe(K_WLOAD, 0, 0, int'(waddr), int'(dc_en & wm_en));
    if (wa_en && !wa_p) observe(K_WARR, 0, 0, int'(waddr), 0);
    if (done && !dn_p)  observe(K_DONE, 0, 0, 0, 0);
    dc_p = dc_en; wm_p = wm_en; wa_p = wa_en; dn_p = done;
  end

  // ---------------- done-strobe responder ----------------
  int dly_wm = 3, dly_wa = 3, dly_dc = 3;
  int cnt_wm = 0, cnt_wa = 0, cnt_dc = 0;
  bit spur = 0;
  always @(negedge clk) begin
    if (wm_en) begin cnt_wm++; wmd = (cnt_wm == dly_wm); end else begin cnt_wm = 0; wmd = 0; end
    if (wa_en) begin cnt_wa++; wad = (cnt_wa == dly_wa); end else begin cnt_wa = 0; wad = 0; end
    if (dc_en) begin cnt_dc++; dcd = (cnt_dc == dly_dc); end else begin cnt_dc = 0; dcd = 0; end
    if (spur && dc_en) wad = 1;
  end

  // ---------------- stimulus helpers ----------------
  task automatic run_start(input logic [2:0] r, input logic [2:0] c, input logic ov);
    @(negedge clk);
    num_tile_rows = r; num_tile_cols = c; overlap_en = ov;
    base_weight = 16'(BW); base_data = 16'(BD);
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (!done && k < 2000) begin @(negedge clk); k++; end
    check({name, " done_seen"}, int'(done), 1);
    @(negedge clk);
    check({name, " busy_after"}, int'(busy), 0);
    check({name, " done_width"}, int'(done), 0);
    repeat (2) @(negedge clk);
    check({name, " queue_drained"}, exp_q.size(), 0);
  endtask

  function automatic int outs_or();
    return int'(wm_en | wa_en | dc_en | busy | done | (|waddr) | (|daddr) | (|row) | (|col));
  endfunction

  task automatic push_1x1();
    ex(K_WLOAD, 0, 0, BW, 0);
    ex(K_WARR, 0, 0, BW, 0);
    ex(K_TILE, 0, 0, BD, 0);
    ex(K_DONE, 0, 0, 0, 0);
  endtask

  // 3 row tiles x 2 column tiles; ov marks the column-1 load overlapping tile (2,0)
  task automatic push_3x2(input int ov);
    ex(K_WLOAD, 0, 0, BW, 0);
    ex(K_WARR, 0, 0, BW, 0);
    ex(K_TILE, 0, 0, BD, 0);
    ex(K_TILE, 1, 0, BD + 256, 0);
    ex(K_TILE, 2, 0, BD + 512, ov);
    ex(K_WLOAD, 0, 0, BW + 256, ov);
    ex(K_WARR, 0, 0, BW + 256, 0);
    ex(K_TILE, 0, 1, BD, 0);
    ex(K_TILE, 1, 1, BD + 256, 0);
    ex(K_TILE, 2, 1, BD + 512, 0);
    ex(K_DONE, 0, 0, 0, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int k;
    repeat (3) @(negedge clk);
    check("reset_outputs", outs_or(), 0);
    reset = 0;

    // single tile, one weight load
    dly_wm = 3; dly_wa = 3; dly_dc = 3;
    push_1x1();
    run_start(3'd0, 3'd0, 1'b0);
    wait_done("t1x1");

    // 3x2 without overlap: two serial weight loads
    push_3x2(0);
    run_start(3'd2, 3'd1, 1'b0);
    wait_done("t3x2");

    // overlap, prefetch done before calc done
    dly_wm = 3; dly_dc = 6;
    push_3x2(1);
    run_start(3'd2, 3'd1, 1'b1);
    wait_done("ovl_early_pf");

    // overlap, prefetch done and calc done in the same cycle
    dly_wm = 4; dly_dc = 4;
    push_3x2(1);
    run_start(3'd2, 3'd1, 1'b1);
    wait_done("ovl_same");

    // overlap, calc done five cycles before prefetch done: load enable stays high
    dly_wm = 8; dly_dc = 3;
    push_3x2(1);
    run_start(3'd2, 3'd1, 1'b1);
    wait_done("ovl_late_pf");

    // start while busy and spurious fifo-arr done during calc are ignored
    dly_wm = 3; dly_dc = 3;
    push_3x2(0);
    run_start(3'd2, 3'd1, 1'b0);
    spur = 1;
    repeat (20) @(negedge clk);
    num_tile_rows = 0; num_tile_cols = 0; base_weight = 16'h7700; base_data = 16'h0;
    start = 1;
    @(negedge clk);
    start = 0;
    wait_done("busy_start_spur");
    spur = 0;

    // reset in the middle of tile (1,0)
    ex(K_WLOAD, 0, 0, BW, 0);
    ex(K_WARR, 0, 0, BW, 0);
    ex(K_TILE, 0, 0, BD, 0);
    ex(K_TILE, 1, 0, BD + 256, 0);
    run_start(3'd2, 3'd1, 1'b0);
    k = 0;
    while (!(dc_en && row == 3'd1) && k < 2000) begin @(negedge clk); k++; end
    check("reach_tile_1_0", int'(dc_en && row == 3'd1), 1);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    check("midrun_reset_outputs", outs_or(), 0);
    reset = 0;
    repeat (3) @(negedge clk);
    check("midrun_reset_idle", outs_or(), 0);
    check("midrun_queue", exp_q.size(), 0);
    push_1x1();
    run_start(3'd0, 3'd0, 1'b0);
    wait_done("after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/master_tile_seq.md
MASTER_TILE_SEQ -- requirements
Module: master_tile_seq

Interface
REQ-001 Parameter WIDTH_HEIGHT, default 16, is the systolic array edge and the tile size in rows and columns.
REQ-002 Parameter MAX_OUT_ROWS, default 128, is the maximum output rows; ROW_W = $clog2(MAX_OUT_ROWS/WIDTH_HEIGHT).
REQ-003 Parameter MAX_OUT_COLS, default 128, is the maximum output columns; COL_W = $clog2(MAX_OUT_COLS/WIDTH_HEIGHT).
REQ-004 Parameter ADDR_W, default 16, is the memory address width.
REQ-005 The block SHALL use one clock, clk; reset is synchronous and active-high.
REQ-006 Ports, as name, direction, width and meaning:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- start  in  1  one-cycle request to begin a multiply.
- overlap_en  in  1  enables weight prefetch during calc; sampled at start.
- num_tile_rows  in  ROW_W  number of row tiles minus 1.
- num_tile_cols  in  COL_W  number of column tiles minus 1.
- base_weight  in  ADDR_W  base address of the weights.
- base_data  in  ADDR_W  base address of the data.
- weight_mem_fifo_done  in  1  done strobe for the weight mem-to-fifo phase.
- weight_fifo_arr_done  in  1  done strobe for the weight fifo-to-array phase.
- data_mem_calc_done  in  1  done strobe for the data mem-to-calc phase.
- weight_mem_fifo_en  out  1  weight load from memory to fifo.
- weight_fifo_arr_en  out  1  weight shift from fifo to array.
- data_mem_calc_en  out  1  data stream and calculate.
- weight_addr  out  ADDR_W  weight tile address.
- data_addr  out  ADDR_W  data tile address.
- accum_table_submat_row  out  ROW_W  current row tile index.
- accum_table_submat_col  out  COL_W  current column tile index.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle completion pulse.

Function
REQ-007 States SHALL be IDLE, W_MEM_FIFO, W_FIFO_ARR, D_MEM_CALC and FINISH, held in a registered state vector.
REQ-008 In IDLE, start=1 SHALL latch all config inputs, clear both tile indices, set busy and go to W_MEM_FIFO.
REQ-009 While busy, start SHALL be ignored.
REQ-010 Tile order SHALL be column outer, row inner: the row index increments per D_MEM_CALC completion, and the column index increments when the row index wraps from num_tile_rows to 0.
REQ-011 weight_addr SHALL equal base_weight + col*WIDTH_HEIGHT*WIDTH_HEIGHT, and data_addr SHALL equal base_data + row*WIDTH_HEIGHT*WIDTH_HEIGHT, truncated to ADDR_W.
REQ-012 Each enable SHALL be high every cycle its phase is active; a done strobe sampled high SHALL advance the state, and the enable SHALL be low in the following cycle unless that phase is re-entered.
REQ-013 W_MEM_FIFO SHALL go to W_FIFO_ARR on done; W_FIFO_ARR SHALL go to D_MEM_CALC on done.
REQ-014 On D_MEM_CALC done:
- last row and last column: go to FINISH.
- row wrap (new column): go to W_MEM_FIFO, or to W_FIFO_ARR if the prefetch completed.
- otherwise: stay in D_MEM_CALC for the next row tile, and deassert data_mem_calc_en for exactly one cycle between tiles.
REQ-015 Weights SHALL be loaded once per column tile; row tiles within a column SHALL reuse the loaded weights.
REQ-016 Overlap: with overlap_en latched and the last row tile of a non-last column in D_MEM_CALC, weight_mem_fifo_en SHALL assert alongside data_mem_calc_en, and weight_addr SHALL point to column col+1 until the prefetch done is seen.
REQ-017 A prefetch done SHALL set a prefetch_ok flag that is cleared on entering W_FIFO_ARR.
REQ-018 Calc done and prefetch done in the same cycle SHALL both be honoured, going directly to W_FIFO_ARR.
REQ-019 If calc done arrives before prefetch done, the block SHALL go to W_MEM_FIFO with weight_mem_fifo_en held continuously high, with no low cycle.
REQ-020 Done strobes arriving while their phase is inactive SHALL be ignored.
REQ-021 FINISH SHALL pulse done for one cycle, clear busy, and return to IDLE.
REQ-022 num_tile_rows=0 and num_tile_cols=0 SHALL run exactly one tile with one weight load.

Reset
REQ-023 Reset SHALL force IDLE in the cycle after it is sampled, from any state, including mid-phase.
REQ-024 Reset SHALL clear all enables, busy, done, prefetch_ok, both indices, weight_addr and data_addr to 0.
REQ-025 Reset SHALL take priority over start and over every done strobe.

Structure
REQ-026 State encodings and the ROW_W/COL_W width functions SHALL reside in shared package tpu_ctrl_pkg.
REQ-027 A tile_counter sub-module (row/col index pair with wrap and last flags) SHALL be instantiated once.
REQ-028 All outputs SHALL be registered or be a decode of registered state only.

Verification
REQ-029 Setup 1x1 tiles, overlap=0, each done strobe 3 cycles after its enable -> en sequence W_MEM_FIFO, W_FIFO_ARR, D_MEM_CALC; done pulse; busy low after.
REQ-030 Setup 3 row tiles x 2 col tiles, overlap=0 -> 2 weight loads; submat_row/col sequence (0,0)(1,0)(2,0)(0,1)(1,1)(2,1); data_addr steps of 256.
REQ-031 Same setup, overlap=1, prefetch done before calc done -> the column-1 load overlaps tile (2,0), and D_MEM_CALC done goes straight to W_FIFO_ARR with weight_addr=base_weight+256.
REQ-032 Overlap with calc done and prefetch done in the same cycle, and separately calc done 5 cycles earlier -> same cycle goes to W_FIFO_ARR; the early case holds weight_mem_fifo_en unbroken until prefetch done.
REQ-033 Reset mid-D_MEM_CALC at tile (1,0) -> next cycle all outputs 0 and IDLE; a new start runs cleanly from (0,0).
REQ-034 Start while busy, plus spurious weight_fifo_arr_done in D_MEM_CALC -> no effect; the tile sequence is unchanged.
